irq_controller: RTL
===================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter N_SRC, default 6, giving the number of interrupt sources (1..8).
REQ-002 SHALL have port clk, input, 1 bit, the single system clock.
REQ-003 SHALL have port reset, input, 1 bit; asynchronous, active-high.
REQ-004 SHALL have port addr, input, 2 bits, word address of the register window, driven from the bridge.
REQ-005 SHALL have port we, input, 1 bit, register write enable.
REQ-006 SHALL have port WD, input, 32 bits, write data.
REQ-007 SHALL have port RD, output, 32 bits, read data.
REQ-008 SHALL have port irq_in, input, N_SRC bits, raw device IRQs (timer0 on bit 0, timer1 on bit 1).
REQ-009 SHALL have port HWInt, output, 6 bits, CPU interrupt lines; bits at and above N_SRC are tied to 0.

Function
REQ-010 SHALL use this register map: addr 0 = PEND (read; write-1-to-clear), addr 1 = MASK (read/write), addr 2 = MODE (read/write; 1 = edge, 0 = level), addr 3 = ID (read-only).
REQ-011 SHALL drive RD combinationally from addr; register bits above N_SRC SHALL read 0.
REQ-012 SHALL, for each level-mode source, load PEND[i] with irq_in[i] on every clk edge, giving 1-cycle latency; writes to PEND SHALL be ignored for that bit.
REQ-013 SHALL, for each edge-mode source, register irq_in into prev_irq every cycle and set PEND[i] on the edge where irq_in[i]=1 and prev_irq[i]=0; the bit stays set until cleared.
REQ-014 SHALL clear edge-mode PEND[i] on a write to addr 0 with WD[i]=1; if a rising edge and the clear fall on the same cycle, set SHALL win.
REQ-015 SHALL drive HWInt[i] = PEND[i] & MASK[i], combinationally from registers; no extra delay.
REQ-016 SHALL return ID as {valid in bit 31, 28'b0, index in bits 2:0}, where index is the lowest i with PEND[i]&MASK[i]=1 (lowest index = highest priority); with no such i, ID SHALL read 0.
REQ-017 SHALL make MASK/MODE writes take effect on the edge of the write; a MODE change from edge to level SHALL let the next edge reload PEND[i] from irq_in[i].
REQ-018 SHALL ignore writes to addr 3.

Reset
REQ-019 SHALL, while reset=1, hold PEND=0, MASK=0, MODE=0 and prev_irq=0, so that HWInt=0 and ID=0.
REQ-020 SHALL, when reset asserts mid-operation, clear all state immediately without waiting for a clk edge; irq_in already high at release SHALL NOT count as an edge until it has been sampled once, because prev_irq is 0.

Configuration
REQ-021 SHALL honour the macro IRQ_EDGE_DETECT_EN: when it is defined, the MODE register and edge logic are present as described above.
REQ-022 SHALL, without IRQ_EDGE_DETECT_EN, treat all sources as level-mode; MODE SHALL read 0, writes to MODE and PEND SHALL be ignored, and no prev_irq flops SHALL exist.

Structure
REQ-023 SHALL take the register address constants (PEND, MASK, MODE, ID), the ID valid-bit position and the CPU HWInt width (6) from the shared package irq_pkg.
REQ-024 SHALL place the lowest-index priority encoder in one sub-module, irq_prio_enc (input N_SRC-bit vector; outputs valid and 3-bit index); everything else stays in irq_controller.

Verification
REQ-025 Level-mode check SHALL cover: after reset, write MASK=0x3, hold irq_in=0x01 -> HWInt=0x01 one cycle later and ID=0x80000000; drop irq_in -> HWInt=0 one cycle later.
REQ-026 Edge-mode check SHALL cover: write MODE=0x2, MASK=0x2, pulse irq_in[1] for 1 cycle -> PEND=0x2 stays set; write 0x2 to addr 0 -> PEND=0, HWInt=0.
REQ-027 Simultaneous set/clear check SHALL cover: in edge mode, a rising edge on irq_in[1] in the same cycle as a W1C of bit 1 -> PEND[1]=1 afterwards.
REQ-028 Priority/mask check SHALL cover: MASK=0x3F, irq_in=0x24 -> ID=0x80000002; then MASK=0x20 -> ID=0x80000005, HWInt=0x20.
REQ-029 Reset check SHALL cover: with PEND=0x3, assert reset between clk edges -> HWInt=0 and RD at every address =0 before the next edge.
REQ-030 Macro-off check SHALL cover: build without IRQ_EDGE_DETECT_EN, write MODE=0x3F -> MODE reads 0 and 1-cycle pulses on irq_in do not stay in PEND.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register addresses, ID word
// layout and CPU interrupt line width.
package irq_pkg;

  localparam int unsigned ADDR_W       = 2;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned HWINT_W      = 6;
  localparam int unsigned ID_VALID_BIT = 31;
  localparam int unsigned ID_IDX_W     = 3;

  typedef enum logic [ADDR_W-1:0] {
    REG_PEND = 2'd0,
    REG_MASK = 2'd1,
    REG_MODE = 2'd2,
    REG_ID   = 2'd3
  } reg_addr_e;

  // Build the ID word: valid flag on top, source index in the low bits.
  function automatic logic [DATA_W-1:0] id_word(input logic valid,
                                                input logic [ID_IDX_W-1:0] idx);
    id_word = '0;
    if (valid) begin
      id_word[ID_VALID_BIT]  = 1'b1;
      id_word[ID_IDX_W-1:0] = idx;
    end
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the active interrupt vector.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0]          req_i,
  output logic                  valid_o,
  output logic [ID_IDX_W-1:0]   idx_o
);

  // Scan from the top down so the lowest set index is the last one kept.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = ID_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: pending/mask/mode registers behind a 4-word window,
// masked CPU interrupt lines and a highest-priority ID register.
// Optional edge detection is compiled in with IRQ_EDGE_DETECT_EN; without it
// every source is level-mode, MODE reads 0 and PEND ignores writes.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                we,
  input  logic [DATA_W-1:0]   WD,
  output logic [DATA_W-1:0]   RD,
  input  logic [N_SRC-1:0]    irq_in,
  output logic [HWINT_W-1:0]  HWInt
);

  logic [N_SRC-1:0]    pend_q, pend_d;
  logic [N_SRC-1:0]    mask_q, mask_d;
  logic [N_SRC-1:0]    active;
  logic                id_valid;
  logic [ID_IDX_W-1:0] id_idx;
  logic                wr_mask;
  logic [N_SRC-1:0]    wd_src;
  logic                unused_wd;

  assign wd_src    = WD[N_SRC-1:0];
  assign wr_mask   = we && (addr == REG_MASK);
  assign unused_wd = ^{1'b0, WD};

`ifdef IRQ_EDGE_DETECT_EN
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;

  assign rise = irq_in & ~prev_q;
  assign clr  = (we && (addr == REG_PEND)) ? wd_src : '0;

  // Edge sources: a rising edge sets (and beats a same-cycle clear); level sources follow irq_in.
  always_comb begin
    mode_d = mode_q;
    if (we && (addr == REG_MODE)) begin
      mode_d = wd_src;
    end
    pend_d = (mode_q & (rise | (pend_q & ~clr))) | (~mode_q & irq_in);
  end

  // Mode and previous-sample registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= '0;
      prev_q <= '0;
    end else begin
      mode_q <= mode_d;
      prev_q <= irq_in;
    end
  end
`else
  // All sources are level-mode: PEND simply samples irq_in.
  always_comb begin
    pend_d = irq_in;
  end
`endif

  // Mask register write.
  always_comb begin
    mask_d = mask_q;
    if (wr_mask) begin
      mask_d = wd_src;
    end
  end

  // Pending and mask registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  assign active = pend_q & mask_q;
  assign HWInt  = HWINT_W'(active);

  irq_prio_enc #(
    .N (N_SRC)
  ) u_prio_enc (
    .req_i   (active),
    .valid_o (id_valid),
    .idx_o   (id_idx)
  );

  // Combinational read mux over the register window.
  always_comb begin
    RD = '0;
    case (reg_addr_e'(addr))
      REG_PEND: RD = DATA_W'(pend_q);
      REG_MASK: RD = DATA_W'(mask_q);
`ifdef IRQ_EDGE_DETECT_EN
      REG_MODE: RD = DATA_W'(mode_q);
`else
      REG_MODE: RD = '0;
`endif
      REG_ID:   RD = id_word(id_valid, id_idx);
      default:  RD = '0;
    endcase
  end

endmodule
